// File: rtl/sign_narrow_pkg.sv
// Shared widths, mode encodings and saturation limits for the narrowing path.
// The field widths match the sign-extend blocks so values round-trip exactly.
package sign_narrow_pkg;
   localparam int IMM_W = 18;
   localparam int MD_W  = 22;
   localparam int CNT_W = 16;

   localparam logic MODE_IMM = 1'b0;
   localparam logic MODE_MD  = 1'b1;

   localparam logic [IMM_W-1:0] IMM_SAT_POS = {1'b0, {(IMM_W-1){1'b1}}};
   localparam logic [IMM_W-1:0] IMM_SAT_NEG = {1'b1, {(IMM_W-1){1'b0}}};
   localparam logic [MD_W-1:0]  MD_SAT_POS  = {1'b0, {(MD_W-1){1'b1}}};
   localparam logic [MD_W-1:0]  MD_SAT_NEG  = {1'b1, {(MD_W-1){1'b0}}};

   typedef struct packed {
      logic [31:0] data;
      logic        mode;
      logic        sat;
   } s1_t;

   typedef struct packed {
      logic [MD_W-1:0] field;
      logic            ovf;
      logic            mode;
   } s2_t;
endpackage

// File: rtl/sign_narrow_if.sv
// Input/output handshake bundle of the narrowing pipeline.
interface sign_narrow_if import sign_narrow_pkg::*; ;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_data;
   logic            in_mode;
   logic            in_sat;
   logic            out_valid;
   logic            out_ready;
   logic [MD_W-1:0] out_field;
   logic            out_ovf;
   logic            out_mode;

   modport slave (
      input  in_valid, in_data, in_mode, in_sat, out_ready,
      output in_ready, out_valid, out_field, out_ovf, out_mode
   );

   modport master (
      output in_valid, in_data, in_mode, in_sat, out_ready,
      input  in_ready, out_valid, out_field, out_ovf, out_mode
   );
endinterface

// File: rtl/sign_narrow_narrow_core.sv
// Combinational fit check and truncate/saturate for one field width N.
module narrow_core #(
   parameter int            N       = 18,
   parameter logic [N-1:0]  SAT_POS = {1'b0, {(N-1){1'b1}}},
   parameter logic [N-1:0]  SAT_NEG = {1'b1, {(N-1){1'b0}}}
) (
   input  logic [31:0]  data,
   input  logic         sat,
   output logic [N-1:0] field,
   output logic         ovf
);
   // Value round-trips through sign extension only if bits [31:N-1] agree.
   logic [32-N:0] hi;
   assign hi  = data[31:N-1];
   assign ovf = !((&hi) || !(|hi));

   always_comb begin
      field = data[N-1:0];
      if (ovf && sat)
         field = data[31] ? SAT_NEG : SAT_POS;
   end
endmodule

// File: rtl/sign_narrow.sv
// Two-stage valid/ready pipeline narrowing 32-bit values into IMM or Md fields,
// with a saturating count of overflowing results taken downstream.
module sign_narrow import sign_narrow_pkg::*; #(
   parameter int OVF_CNT_W = CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   sign_narrow_if.slave         bus,
   output logic [OVF_CNT_W-1:0] ovf_cnt,
   input  logic                 cnt_clr
);
   localparam int STAGES = 2;

   logic [STAGES:1] vld_pipe;
   s1_t             s1;
   s2_t             s2;
   s2_t             nxt;
   logic            s2_load;

   logic [IMM_W-1:0] imm_field;
   logic             imm_ovf;
   logic [MD_W-1:0]  md_field;
   logic             md_ovf;

   narrow_core #(.N(IMM_W), .SAT_POS(IMM_SAT_POS), .SAT_NEG(IMM_SAT_NEG)) u_imm (
      .data (s1.data),
      .sat  (s1.sat),
      .field(imm_field),
      .ovf  (imm_ovf)
   );

   narrow_core #(.N(MD_W), .SAT_POS(MD_SAT_POS), .SAT_NEG(MD_SAT_NEG)) u_md (
      .data (s1.data),
      .sat  (s1.sat),
      .field(md_field),
      .ovf  (md_ovf)
   );

   always_comb begin
      nxt.mode  = s1.mode;
      nxt.ovf   = (s1.mode == MODE_MD) ? md_ovf : imm_ovf;
      nxt.field = (s1.mode == MODE_MD) ? md_field
                                       : {{(MD_W-IMM_W){1'b0}}, imm_field};
   end

   // out_ready feeds straight through to in_ready so a full pipe streams.
   assign s2_load      = !vld_pipe[2] || bus.out_ready;
   assign bus.in_ready = !reset && (!vld_pipe[1] || s2_load);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         s1       <= '0;
         s2       <= '0;
         ovf_cnt  <= '0;
      end else begin
         if (s2_load) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) s2 <= nxt;
         end
         if (bus.in_ready) begin
            vld_pipe[1] <= bus.in_valid;
            if (bus.in_valid) s1 <= '{data: bus.in_data, mode: bus.in_mode, sat: bus.in_sat};
         end
         if (cnt_clr)
            ovf_cnt <= '0;
         else if (vld_pipe[2] && bus.out_ready && s2.ovf && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + 1'b1;
      end
   end

   assign bus.out_valid = vld_pipe[2];
   assign bus.out_field = s2.field;
   assign bus.out_ovf   = s2.ovf;
   assign bus.out_mode  = s2.mode;
endmodule

// File: tb/tb_sign_narrow.sv
// Directed scoreboard bench for sign_narrow: driver queues expected results,
// a negedge monitor pops and compares them and checks stall stability.
module tb_sign_narrow;
   import sign_narrow_pkg::*;

   localparam int TB_CNT_W = 8;

   logic                clk = 1'b0;
   logic                reset;
   logic                cnt_clr;
   logic [TB_CNT_W-1:0] ovf_cnt;

   sign_narrow_if bus();

   sign_narrow #(.OVF_CNT_W(TB_CNT_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .ovf_cnt(ovf_cnt),
      .cnt_clr(cnt_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [MD_W-1:0] field;
      logic            ovf;
      logic            mode;
      int              acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errs   = 0;
   int   cyc    = 0;
   int   n_acc  = 0;
   bit   chk_lat;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic m, input logic s,
                       input logic [MD_W-1:0] ef, input logic eo);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = m;
      bus.in_sat   = s;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", {31'd0, bus.in_ready}, 32'd1);
      if (bus.in_ready) begin
         e.field = ef; e.ovf = eo; e.mode = m; e.acc = cyc;
         q.push_back(e);
         n_acc++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      bus.in_mode  = 1'($urandom);
      bus.in_sat   = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", q.size(), 0);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: compares on every handshake; while stalled, outputs must hold.
   logic            hold_v = 1'b0;
   logic [MD_W-1:0] hf;
   logic            ho, hm;
   always @(negedge clk) begin
      exp_t e;
      if (reset) hold_v = 1'b0;
      else begin
         if (hold_v) begin
            check("hold_field", 32'(bus.out_field), 32'(hf));
            check("hold_ovf",   32'(bus.out_ovf),   32'(ho));
            check("hold_mode",  32'(bus.out_mode),  32'(hm));
         end
         if (bus.out_valid && bus.out_ready) begin
            hold_v = 1'b0;
            if (q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               check("field", 32'(bus.out_field), 32'(e.field));
               check("ovf",   32'(bus.out_ovf),   32'(e.ovf));
               check("mode",  32'(bus.out_mode),  32'(e.mode));
               if (chk_lat) check("latency", cyc - e.acc, 2);
            end
         end else if (bus.out_valid) begin
            hold_v = 1'b1;
            hf = bus.out_field; ho = bus.out_ovf; hm = bus.out_mode;
         end else hold_v = 1'b0;
      end
   end

   // Directed vectors: data, mode, sat, expected field, expected ovf.
   localparam int NV = 11;
   logic [31:0]     v_d  [NV] = '{32'h0001FFFF, 32'hFFFE0000, 32'h00020000, 32'h00020000,
                                  32'hFFFDFFFF, 32'hFFFDFFFF, 32'h001FFFFF, 32'h00200000,
                                  32'h80000000, 32'hFFE00000, 32'h00000005};
   logic            v_m  [NV] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
   logic            v_s  [NV] = '{0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1};
   logic [MD_W-1:0] v_f  [NV] = '{22'h1FFFF, 22'h20000, 22'h20000, 22'h1FFFF,
                                  22'h1FFFF, 22'h20000, 22'h1FFFFF, 22'h1FFFFF,
                                  22'h200000, 22'h200000, 22'h5};
   logic            v_o  [NV] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; cnt_clr = 1'b0; chk_lat = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 1'b0; bus.in_sat = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  32'(bus.in_ready),  0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_field", 32'(bus.out_field), 0);
      check("rst_out_ovf",   32'(bus.out_ovf),   0);
      check("rst_out_mode",  32'(bus.out_mode),  0);
      check("rst_ovf_cnt",   32'(ovf_cnt),       0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 1);

      // Back-to-back directed vectors, unstalled.
      for (int i = 0; i < NV; i++) send(v_d[i], v_m[i], v_s[i], v_f[i], v_o[i]);
      drain();
      check("cnt_after_vectors", 32'(ovf_cnt), 6);

      @(posedge clk); #1 cnt_clr = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      @(negedge clk);
      check("cnt_clear", 32'(ovf_cnt), 0);

      repeat (3) send(32'h00020000, MODE_IMM, 1'b0, 22'h20000, 1'b1);
      drain();
      check("cnt_three", 32'(ovf_cnt), 3);

      // Clear coincident with a fourth overflow handshake.
      chk_lat = 1'b0;
      @(posedge clk); #1 bus.out_ready = 1'b0;
      send(32'h7FFFFFFF, MODE_MD, 1'b1, 22'h1FFFFF, 1'b1);
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
      check("stall_out_valid", 32'(bus.out_valid), 1);
      check("cnt_before_clr", 32'(ovf_cnt), 3);
      @(posedge clk); #1 cnt_clr = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      @(negedge clk);
      check("cnt_clr_wins", 32'(ovf_cnt), 0);
      drain();

      // Backpressure: five words against a stalled output.
      @(posedge clk); #1 bus.out_ready = 1'b0;
      n_acc = 0;
      fork
         for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            d = 32'h1000 * (i + 1) + i;
            send(d, 1'(i), 1'b1, 22'(d), 1'b0);
         end
         begin
            repeat (4) @(negedge clk);
            check("bp_accepts", n_acc, 2);
            check("bp_in_ready", 32'(bus.in_ready), 0);
            @(posedge clk); #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // Saturate the counter with a dense overflow stream.
      chk_lat = 1'b1;
      for (int i = 0; i < 260; i++) send(32'h80000000, MODE_MD, 1'b1, 22'h200000, 1'b1);
      drain();
      check("cnt_saturated", 32'(ovf_cnt), 32'hFF);

      // Reset with both stages occupied.
      chk_lat = 1'b0;
      @(posedge clk); #1 bus.out_ready = 1'b0;
      send(32'h00000011, MODE_IMM, 1'b0, 22'h11, 1'b0);
      send(32'h00000022, MODE_IMM, 1'b0, 22'h22, 1'b0);
      @(negedge clk);
      check("full_out_valid", 32'(bus.out_valid), 1);
      check("full_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk); #1 reset = 1'b1;
      q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_rst_out_valid", 32'(bus.out_valid), 0);
      check("mid_rst_ovf_cnt",   32'(ovf_cnt),       0);
      check("mid_rst_in_ready",  32'(bus.in_ready),  0);
      @(posedge clk); #1 reset = 1'b0; bus.out_ready = 1'b1; chk_lat = 1'b1;
      send(32'hFFE00000, MODE_MD, 1'b0, 22'h200000, 1'b0);
      drain();
      check("post_rst_cnt", 32'(ovf_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/sign_narrow.md
Name: sign_narrow

Overview:
- Inverse of the immediate/Md sign extenders: takes a 32-bit two's-complement value and narrows it to an 18-bit immediate field or a 22-bit Md field.
- Detects values that do not round-trip through sign extension; optionally saturates them.
- Sits on the instruction-build / loader path that packs computed offsets into instruction words.
- Two-stage valid/ready pipeline with a saturating overflow event counter.

Parameters:
- IMM_W, 18, immediate field width.
- MD_W, 22, Md field width (must be ≥ IMM_W).
- CNT_W, 16, overflow counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  32  value to narrow.
- in_mode  in  1  0 = IMM_W field, 1 = MD_W field.
- in_sat  in  1  1 = saturate on overflow, 0 = truncate.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_field  out  MD_W  narrowed field, right-aligned; in IMM mode bits [MD_W-1:IMM_W] = 0.
- out_ovf  out  1  value did not fit the selected width.
- out_mode  out  1  mode of the result, passed through.
- ovf_cnt  out  CNT_W  accepted overflow results, saturating.
- cnt_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset values: in_ready=0 during reset then 1; out_valid=0; out_field=0; out_ovf=0; out_mode=0; ovf_cnt=0. Reset mid-operation discards both stages; no partial result is emitted.
- Fit rule for width N: fits iff in_data[31:N-1] are all equal.
- Truncate (in_sat=0): field = in_data[N-1:0].
- Saturate (in_sat=1) on overflow:
  - in_data[31]=0 → field = 0 followed by N-1 ones (max positive).
  - in_data[31]=1 → field = 1 followed by N-1 zeros (min negative).
- out_ovf=1 whenever the value does not fit, regardless of in_sat.
- Stage 1 (S1): captures in_data, in_mode and in_sat on in_valid && in_ready.
- Stage 2 (S2): registers the computed field, ovf and mode. Latency is exactly 2 cycles from accept to out_valid when unstalled.
- Throughput is 1 result/cycle when out_ready=1.
- Ready logic:
  - S2 may load when S2 is empty or out_ready=1.
  - S1 may advance when S2 may load.
  - in_ready = !S1 valid || S1 may advance.
  - Combinational path from out_ready to in_ready is permitted.
- Full pipeline with out_ready=0: in_ready=0 and all stage contents hold stable. out_field, out_ovf and out_mode must not change while out_valid && !out_ready.
- Simultaneous input accept and output accept: both happen; no bubble, no loss.
- ovf_cnt increments on out_valid && out_ready && out_ovf. It holds at all-ones (no wrap).
- cnt_clr is asserted in the same cycle as an increment: clear wins, result 0.
- in_data and in_mode must not affect any output unless in_valid && in_ready.

Decomposition:
- Shared header/package sign_narrow_defs:
  - IMM_W and MD_W constants shared with the sign-extend blocks.
  - Mode encodings MODE_IMM=0, MODE_MD=1.
  - Saturation-limit constants per width.
- Sub-module narrow_core: combinational fit check plus truncate/saturate for one width N, instantiated twice (IMM_W, MD_W). sign_narrow holds the pipeline, handshake and counter.

Test Plan:
- IMM, sat=0, in_data=0x0001FFFF → out_field=0x1FFFF, ovf=0, 2 cycles after accept. Repeat with 0xFFFE0000 → 0x20000, ovf=0.
- IMM, in_data=0x00020000: sat=0 → field 0x20000, ovf=1; sat=1 → field 0x1FFFF, ovf=1. In both cases bits [21:18]=0. Repeat with 0xFFFDFFFF: sat=0 → 0x1FFFF; sat=1 → 0x20000; ovf=1 in both.
- MD mode:
  - 0x001FFFFF → 0x1FFFFF, ovf=0.
  - 0x00200000 with sat=1 → 0x1FFFFF, ovf=1.
  - 0x80000000 with sat=1 → 0x200000, ovf=1.
- Backpressure: stream 5 words with out_ready held 0 for 4 cycles. Required: in_ready drops after 2 accepts, outputs stay stable, and all 5 results emerge in order with no duplicate or drop once out_ready=1.
- Counter: 3 accepted overflow results → ovf_cnt=3. cnt_clr coincident with a 4th overflow accept → 0. Preload near all-ones via repeated overflows → holds at 0xFFFF.
- Reset asserted with both stages full → next cycle out_valid=0, ovf_cnt=0; first post-reset input emerges correctly after 2 cycles.
